// File: rtl/serial_less_than.sv
// Bit-serial unsigned comparator: subtracts b from a one bit per clock, LSB first,
// and reports the difference together with less-than and equal flags.
module serial_less_than #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         less,
    output logic         equal
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   aShift_q, bShift_q, diffShift_q, diffShift_d;
    logic           borrow_q, borrow_d;
    logic           nonzero_q, nonzero_d;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   diff_q;
    logic           less_q, equal_q;
    logic           lastBit;
    logic           bitDiff;

    assign lastBit = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (lastBit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // One full-subtractor step on the current operand LSBs
    always_comb begin
        bitDiff     = aShift_q[0] ^ bShift_q[0] ^ borrow_q;
        borrow_d    = (~aShift_q[0] & bShift_q[0]) | (~(aShift_q[0] ^ bShift_q[0]) & borrow_q);
        diffShift_d = {bitDiff, diffShift_q[N-1:1]};
        nonzero_d   = nonzero_q | bitDiff;
    end

    // Result registers are loaded only on completion, so an aborted run leaves no trace
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aShift_q    <= '0;
            bShift_q    <= '0;
            diffShift_q <= '0;
            borrow_q    <= 1'b0;
            nonzero_q   <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        aShift_q    <= a;
                        bShift_q    <= b;
                        diffShift_q <= '0;
                        borrow_q    <= 1'b0;
                        nonzero_q   <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                BUSY: begin
                    aShift_q    <= aShift_q >> 1;
                    bShift_q    <= bShift_q >> 1;
                    diffShift_q <= diffShift_d;
                    borrow_q    <= borrow_d;
                    nonzero_q   <= nonzero_d;
                    cnt_q       <= cnt_q + CW'(1);
                    if (lastBit) begin
                        diff_q  <= diffShift_d;
                        less_q  <= borrow_d;
                        equal_q <= ~nonzero_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff  = diff_q;
    assign less  = less_q;
    assign equal = equal_q;

endmodule

// File: tb/tb_serial_less_than.sv
// Directed and random checks of serial_less_than (N=8): results, latency,
// backpressure, ignored inputs while busy, and asynchronous reset mid-operation.
module tb_serial_less_than;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         less, equal;

    int total = 0;
    int bad   = 0;

    serial_less_than #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .less      (less),
        .equal     (equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       less;
        logic       equal;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Submit one pair and check latency, result and handshake completion.
    task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                                 input logic [7:0] eDiff, input logic eLess,
                                 input logic eEq, input bit stall);
        int waitCyc;
        int lat;
        int n;
        bit hs;
        waitCyc = 0;
        while (!in_ready && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("in_ready before accept", 32'(in_ready), 1);
        in_valid = 1'b1;
        a = aIn;
        b = bIn;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (stall) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, N);
        checkOutput("diff", 32'(diff), 32'(eDiff));
        checkOutput("less", 32'(less), 32'(eLess));
        checkOutput("equal", 32'(equal), 32'(eEq));
        if (stall) begin
            n = 0;
            do begin
                out_ready = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                hs = out_ready;
                @(negedge clk);
                n++;
                if (!hs) checkOutput("diff held in stall", 32'(diff), 32'(eDiff));
            end while (!hs);
        end else begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checkOutput("out_valid after handshake", 32'(out_valid), 0);
        checkOutput("in_ready after handshake", 32'(in_ready), 1);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        logic [7:0] ra, rb;

        vecs[0]  = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b1};
        vecs[1]  = '{8'd2,   8'd2,   8'd0,   1'b0, 1'b1};
        vecs[2]  = '{8'd2,   8'd1,   8'd1,   1'b0, 1'b0};
        vecs[3]  = '{8'd255, 8'd1,   8'd254, 1'b0, 1'b0};
        vecs[4]  = '{8'd127, 8'd128, 8'd255, 1'b1, 1'b0};
        vecs[5]  = '{8'd0,   8'd255, 8'd1,   1'b1, 1'b0};
        vecs[6]  = '{8'd200, 8'd100, 8'd100, 1'b0, 1'b0};
        vecs[7]  = '{8'd100, 8'd200, 8'd156, 1'b1, 1'b0};
        vecs[8]  = '{8'd1,   8'd0,   8'd1,   1'b0, 1'b0};
        vecs[9]  = '{8'd128, 8'd127, 8'd1,   1'b0, 1'b0};
        vecs[10] = '{8'd255, 8'd255, 8'd0,   1'b0, 1'b1};
        vecs[11] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #2;
        checkOutput("reset in_ready", 32'(in_ready), 1);
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset diff", 32'(diff), 0);
        checkOutput("reset less", 32'(less), 0);
        checkOutput("reset equal", 32'(equal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].less, vecs[i].equal, 1'b0);

        // Backpressure with a competing pair held on the input throughout
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd5;
        b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        a = 8'd77;
        b = 8'd1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            checkOutput("in_ready busy", 32'(in_ready), 0);
            @(negedge clk);
            lat++;
        end
        checkOutput("bp latency", lat, N);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp out_valid", 32'(out_valid), 1);
            checkOutput("bp diff", 32'(diff), 252);
            checkOutput("bp less", 32'(less), 1);
            checkOutput("bp in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        checkOutput("bp handshake out_valid", 32'(out_valid), 0);
        checkOutput("bp handshake in_ready", 32'(in_ready), 1);
        repeat (N + 2) @(negedge clk);
        checkOutput("bp pair not consumed", 32'(out_valid), 0);
        checkOutput("bp diff kept", 32'(diff), 252);

        // Asynchronous reset after four busy cycles
        in_valid = 1'b1;
        a = 8'd200;
        b = 8'd100;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset in_ready", 32'(in_ready), 1);
        checkOutput("midreset out_valid", 32'(out_valid), 0);
        checkOutput("midreset diff", 32'(diff), 0);
        checkOutput("midreset less", 32'(less), 0);
        checkOutput("midreset equal", 32'(equal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'd3, 8'd4, 8'd255, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, ra - rb, ra < rb, ra == rb, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
